instr_fetch_unit: RTL

- Reader side of the program-counter path: owns a PC, issues reads to the synchronous instruction memory and returns each fetched word to the core through a valid/ready handshake.
- Sits between the core control unit and instruction memory, one instance per core.
- Supports sequential fetch with wrap-around, jump redirection on handshake, and start/stop control.

---
 rtl/instr_fetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and steps REQ -> WAIT -> VALID for each word
// read from a synchronous instruction memory with one cycle of read latency.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  jumpEn,
   input  logic [ADDR_WIDTH-1:0] jumpAddr,
   output logic                  memRdEn,
   output logic [ADDR_WIDTH-1:0] memAddr,
   input  logic [DATA_WIDTH-1:0] memData,
   output logic [DATA_WIDTH-1:0] instr,
   output logic                  instrValid,
   input  logic                  instrReady,
   output logic [ADDR_WIDTH-1:0] pc
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      VALID
   } state_t;

   state_t state;
   logic   handshake;
   logic   in_idle;
   logic   in_req;
   logic   in_wait;
   logic   in_valid;

   assign memAddr   = pc;
   assign handshake = instrValid & instrReady;

   assign in_idle  = (state == IDLE);
   assign in_req   = (state == REQ);
   assign in_wait  = (state == WAIT);
   assign in_valid = (state == VALID);

   // memRdEn and instrValid are set on entry to REQ / VALID so both
   // come straight from flops and track the state register exactly.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state      <= IDLE;
         pc         <= RESET_PC;
         instr      <= '0;
         instrValid <= 1'b0;
         memRdEn    <= 1'b0;
      end else begin
         unique case (1'b1)
            in_idle: begin
               if (start) begin
                  state   <= REQ;
                  memRdEn <= 1'b1;
               end
            end
            in_req: begin
               state   <= WAIT;
               memRdEn <= 1'b0;
            end
            in_wait: begin
               instr      <= memData;
               pc         <= pc + ADDR_WIDTH'(1);
               instrValid <= 1'b1;
               state      <= VALID;
            end
            in_valid: begin
               if (handshake) begin
                  instrValid <= 1'b0;
                  if (jumpEn) begin
                     pc <= jumpAddr;
                  end
                  if (stop) begin
                     state <= IDLE;
                  end else begin
                     state   <= REQ;
                     memRdEn <= 1'b1;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               instrValid <= 1'b0;
               memRdEn    <= 1'b0;
            end
         endcase
      end
   end

endmodule
